// File: rtl/rng_sop_arbiter.sv
// Two-requester round-robin arbiter that hands out 128-bit TRNG samples, with a TRNG stall watchdog.
// Optional build macro RNG_SOP_ZEROIZE_EN: wipe the holding buffer after delivery and blank rnd_data outside grants.
module rng_sop_arbiter #(
    parameter int STALL_LIMIT = 1023
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] sop_data,
    input  logic         sop_valid,
    input  logic         rng_busy,
    output logic         rd_sop,
    input  logic         req0,
    input  logic         req1,
    output logic         gnt0,
    output logic         gnt1,
    output logic [127:0] rnd_data,
    output logic         rnd_valid,
    output logic         stall_err,
    input  logic         clr_err
);

    localparam logic [15:0] LIMIT = 16'(STALL_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t       r_state;
    logic [127:0] r_buf;
    logic         r_ptr;
    logic         r_rd_sop;
    logic         r_gnt0;
    logic         r_gnt1;
    logic         r_rnd_valid;
    logic [15:0]  r_stall_cnt;
    logic         r_stall_err;

    logic         w_req_any;
    logic         w_pick1;
    logic         w_stall_tick;

    assign w_req_any    = req0 | req1;
    // Requester 1 wins when it is alone or when it holds the priority pointer.
    assign w_pick1      = req1 & (~req0 | r_ptr);
    assign w_stall_tick = (r_state == FETCH) & ~sop_valid & ~rng_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_buf       <= '0;
            r_ptr       <= 1'b0;
            r_rd_sop    <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_rnd_valid <= 1'b0;
        end else begin
            r_rd_sop    <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_rnd_valid <= 1'b0;
`ifdef RNG_SOP_ZEROIZE_EN
            // Wipe after delivery; a fill on the same edge overrides below.
            if (r_rnd_valid) begin
                r_buf <= '0;
            end
`endif
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                end
                FETCH: begin
                    if (sop_valid) begin
                        r_buf    <= sop_data;
                        r_rd_sop <= 1'b1;
                        r_state  <= FULL;
                    end
                end
                FULL: begin
                    if (w_req_any) begin
                        r_gnt1      <= w_pick1;
                        r_gnt0      <= ~w_pick1;
                        r_rnd_valid <= 1'b1;
                        r_ptr       <= ~w_pick1;
                        r_state     <= FETCH;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Watchdog: counts FETCH cycles in which the TRNG neither delivers nor works.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall_tick) begin
            if (r_stall_cnt != 16'hFFFF) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end else begin
            r_stall_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_err <= 1'b0;
        end else if (r_stall_cnt == LIMIT) begin
            r_stall_err <= 1'b1;
        end else if (clr_err) begin
            r_stall_err <= 1'b0;
        end
    end

    assign rd_sop    = r_rd_sop;
    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign rnd_valid = r_rnd_valid;
    assign stall_err = r_stall_err;

`ifdef RNG_SOP_ZEROIZE_EN
    assign rnd_data = r_rnd_valid ? r_buf : '0;
`else
    assign rnd_data = r_buf;
`endif

endmodule

// File: tb/tb_rng_sop_arbiter.sv
// Scoreboard bench for rng_sop_arbiter: fill/grant sequencing, round-robin, stall watchdog, async reset.
// Honours RNG_SOP_ZEROIZE_EN for the rnd_data-after-grant expectation.
module tb_rng_sop_arbiter;

    logic         clk;
    logic         rst_n;
    logic [127:0] sop_data;
    logic         sop_valid;
    logic         rng_busy;
    logic         rd_sop;
    logic         req0;
    logic         req1;
    logic         gnt0;
    logic         gnt1;
    logic [127:0] rnd_data;
    logic         rnd_valid;
    logic         stall_err;
    logic         clr_err;

    typedef struct {
        logic         gid;
        logic [127:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic model_ptr;
    logic prev_rd;

    rng_sop_arbiter #(.STALL_LIMIT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sop_data  (sop_data),
        .sop_valid (sop_valid),
        .rng_busy  (rng_busy),
        .rd_sop    (rd_sop),
        .req0      (req0),
        .req1      (req1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rnd_data  (rnd_data),
        .rnd_valid (rnd_valid),
        .stall_err (stall_err),
        .clr_err   (clr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            if (gnt0 && gnt1) begin
                n_fail++;
                $display("FAIL gnt_exclusive gnt0=%0b gnt1=%0b required not both", gnt0, gnt1);
            end
            n_checks++;
            if (rnd_valid !== (gnt0 | gnt1)) begin
                n_fail++;
                $display("FAIL rnd_valid_tracks_gnt got=%0b required=%0b", rnd_valid, gnt0 | gnt1);
            end
            n_checks++;
            if (rd_sop && prev_rd) begin
                n_fail++;
                $display("FAIL rd_sop_consecutive got two cycles, required single");
            end
            prev_rd = rd_sop;
        end else begin
            prev_rd = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Async assert, release 1 ns after an edge, then one edge so the FSM sits in FETCH.
    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_ptr = 1'b0;
        tick();
    endtask

    task automatic wait_gnt(output bit got);
        got = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (gnt0 || gnt1) begin
                got = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        sop_valid = 0; rng_busy = 0; req0 = 0; req1 = 0; clr_err = 0; sop_data = '0;
        rst_n = 1'b0;
        #3;
        n_checks++;
        if ({rd_sop, gnt0, gnt1, rnd_valid, stall_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b required=00000", {rd_sop, gnt0, gnt1, rnd_valid, stall_err});
        end
        n_checks++;
        if (rnd_data !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_data got=%h required=0", rnd_data);
        end
        apply_reset();
    endtask

    task automatic test_first_fetch();
        tick();
        n_checks++;
        if (rd_sop !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_rd_sop got=%0b required=0", rd_sop);
        end
        sop_valid = 1; sop_data = {16{8'hA5}};
        tick();
        sop_valid = 0;
        n_checks++;
        if (rd_sop !== 1'b1) begin
            n_fail++;
            $display("FAIL first_fill_rd_sop got=%0b required=1", rd_sop);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({rd_sop, gnt0, gnt1} !== 3'b000) begin
                n_fail++;
                $display("FAIL full_no_req got=%b required=000", {rd_sop, gnt0, gnt1});
            end
        end
    endtask

    task automatic test_single_req();
        bit   got;
        exp_t e;
        exp_t x;
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                sop_valid = 1; sop_data = {4{32'h1234_5678}};
                tick();
                sop_valid = 0;
                n_checks++;
                if (rd_sop !== 1'b1) begin
                    n_fail++;
                    $display("FAIL refill_rd_sop got=%0b required=1", rd_sop);
                end
            end
            e.gid  = 1'b0;
            e.data = (k == 0) ? {16{8'hA5}} : {4{32'h1234_5678}};
            sb.push_back(e);
            model_ptr = 1'b1;
            req0 = 1;
            wait_gnt(got);
            req0 = 0;
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("FAIL single_gnt_timeout got=none required=gnt0");
                void'(sb.pop_front());
            end else begin
                x = sb.pop_front();
                if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || rnd_data !== x.data) begin
                    n_fail++;
                    $display("FAIL single_gnt got gnt0=%0b gnt1=%0b data=%h required gnt0=1 data=%h",
                             gnt0, gnt1, rnd_data, x.data);
                end
                tick();
                n_checks++;
`ifdef RNG_SOP_ZEROIZE_EN
                if (rnd_data !== 128'd0) begin
                    n_fail++;
                    $display("FAIL post_gnt_zeroize got=%h required=0", rnd_data);
                end
`else
                if (rnd_data !== x.data) begin
                    n_fail++;
                    $display("FAIL post_gnt_retain got=%h required=%h", rnd_data, x.data);
                end
`endif
            end
        end
    endtask

    task automatic test_alternate();
        bit   got;
        exp_t e;
        exp_t x;
        apply_reset();
        req0 = 1; req1 = 1;
        for (int k = 0; k < 3; k++) begin
            sop_valid = 1; sop_data = {96'd0, 32'hC0DE_0000 + 32'(k)};
            e.gid  = model_ptr;
            e.data = sop_data;
            sb.push_back(e);
            model_ptr = ~model_ptr;
            tick();
            sop_valid = 0;
            wait_gnt(got);
            x = sb.pop_front();
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("FAIL alt_gnt_timeout fill=%0d got=none required=gnt%0d", k, x.gid);
            end else if (gnt1 !== x.gid || gnt0 !== ~x.gid || rnd_data !== x.data) begin
                n_fail++;
                $display("FAIL alt_gnt fill=%0d got gnt0=%0b gnt1=%0b data=%h required gnt%0d data=%h",
                         k, gnt0, gnt1, rnd_data, x.gid, x.data);
            end
        end
        req0 = 0; req1 = 0;
    endtask

    task automatic test_stall();
        bit   got;
        exp_t e;
        exp_t x;
        apply_reset();
        for (int i = 0; i < 4; i++) tick();
        rng_busy = 1;
        tick();
        rng_busy = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++;
            if (stall_err !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_early cycle=%0d got=%0b required=0", i, stall_err);
            end
        end
        clr_err = 1;
        tick();
        n_checks++;
        if (stall_err !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_set_wins got=%0b required=1", stall_err);
        end
        tick();
        clr_err = 0;
        n_checks++;
        if (stall_err !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_clear got=%0b required=0", stall_err);
        end
        tick();
        tick();
        n_checks++;
        if (stall_err !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_stays_clear got=%0b required=0", stall_err);
        end
        sop_valid = 1; sop_data = {2{64'hFEED_FACE_DEAD_BEEF}};
        tick();
        sop_valid = 0;
        n_checks++;
        if (rd_sop !== 1'b1) begin
            n_fail++;
            $display("FAIL late_fill_rd_sop got=%0b required=1", rd_sop);
        end
        e.gid = 1'b1; e.data = {2{64'hFEED_FACE_DEAD_BEEF}};
        sb.push_back(e);
        req1 = 1;
        wait_gnt(got);
        req1 = 0;
        x = sb.pop_front();
        n_checks++;
        if (!got || gnt1 !== 1'b1 || rnd_data !== x.data) begin
            n_fail++;
            $display("FAIL late_gnt1 got gnt1=%0b data=%h required gnt1=1 data=%h", gnt1, rnd_data, x.data);
        end
    endtask

    task automatic test_reset_mid_full();
        bit   got;
        exp_t e;
        exp_t x;
        sop_valid = 1; sop_data = {4{32'h0BAD_F00D}};
        tick();
        sop_valid = 0;
        req1 = 1;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rd_sop, gnt0, gnt1, rnd_valid, stall_err} !== 5'b0 || rnd_data !== 128'd0) begin
            n_fail++;
            $display("FAIL async_reset got=%b data=%h required=00000 data=0",
                     {rd_sop, gnt0, gnt1, rnd_valid, stall_err}, rnd_data);
        end
        tick();
        rst_n = 1'b1;
        model_ptr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (gnt1 !== 1'b0 || gnt0 !== 1'b0) begin
                n_fail++;
                $display("FAIL no_gnt_before_fetch cycle=%0d got gnt1=%0b required=0", i, gnt1);
            end
        end
        sop_valid = 1; sop_data = {4{32'h7777_1111}};
        e.gid = 1'b1; e.data = sop_data;
        sb.push_back(e);
        tick();
        sop_valid = 0;
        wait_gnt(got);
        req1 = 0;
        x = sb.pop_front();
        n_checks++;
        if (!got || gnt1 !== 1'b1 || rnd_data !== x.data) begin
            n_fail++;
            $display("FAIL post_reset_gnt1 got gnt1=%0b data=%h required gnt1=1 data=%h", gnt1, rnd_data, x.data);
        end
    endtask

    initial begin
        prev_rd = 1'b0;
        model_ptr = 1'b0;
        test_reset();
        test_first_fetch();
        test_single_req();
        test_alternate();
        test_stall();
        test_reset_mid_full();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d entries required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rng_sop_arbiter.md
RNG_SOP_ARBITER -- requirements
Module: rng_sop_arbiter

Interface
REQ-001 Parameter: STALL_LIMIT, default 1023, FETCH cycles with sop_valid=0 and rng_busy=0 before stall_err sets; legal range 1..65535.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 sop_data  input  128  TRNG sample output word.
REQ-005 sop_valid  input  1  sop_data holds a fresh sample.
REQ-006 rng_busy  input  1  TRNG currently collecting entropy.
REQ-007 rd_sop  output  1  one-cycle pop strobe to the TRNG sample output.
REQ-008 req0  input  1  requester 0 (host) wants one 128-bit word; held until gnt0.
REQ-009 req1  input  1  requester 1 (crypto engine) wants one 128-bit word; held until gnt1.
REQ-010 gnt0  output  1  one-cycle grant to requester 0.
REQ-011 gnt1  output  1  one-cycle grant to requester 1.
REQ-012 rnd_data  output  128  delivered word, valid when rnd_valid=1.
REQ-013 rnd_valid  output  1  high in exactly the cycles gnt0 or gnt1 is high.
REQ-014 stall_err  output  1  sticky TRNG-stall flag.
REQ-015 clr_err  input  1  clears stall_err.

Function
REQ-016 FSM states: IDLE, FETCH, FULL; IDLE shall transition to FETCH unconditionally on the first clock after reset release.
REQ-017 FETCH: when sop_valid=1 is sampled, the block shall register sop_data into a 128-bit holding buffer, assert rd_sop for exactly that next cycle, and enter FULL on the same edge.
REQ-018 rd_sop shall never assert outside a FETCH->FULL transition and never in two consecutive cycles.
REQ-019 FULL: when req0 or req1 is sampled high, the block shall assert exactly one gnt, assert rnd_valid, drive rnd_data from the buffer for exactly the next cycle, and return to FETCH on that same edge.
REQ-020 Grant latency: one cycle from req sampled in FULL; requests in FETCH wait, no grant until FULL.
REQ-021 Arbitration: round-robin; one priority pointer, which is 0 after reset and toggles to the non-granted requester after each grant; with one requester, that requester wins regardless of pointer.
REQ-022 Simultaneous req0 and req1 in FULL: pointer holder granted; the other is granted after the next fill.
REQ-023 gnt0 and gnt1 shall never be high together.
REQ-024 Each buffer fill shall be delivered at most once; a requester that keeps req high after gnt is treated as a new request.
REQ-025 Stall counter (16 bits): increments each FETCH cycle with sop_valid=0 and rng_busy=0; clears to 0 when rng_busy=1, sop_valid=1 or state is not FETCH.
REQ-026 stall_err shall set the cycle after the counter equals STALL_LIMIT and hold until clr_err=1 is sampled; set wins over simultaneous clr_err.
REQ-027 stall_err shall not block FSM operation; a late sop_valid shall still be accepted.

Reset
REQ-028 rst_n low shall asynchronously force: state IDLE, rd_sop=0, gnt0=0, gnt1=0, rnd_valid=0, stall_err=0, pointer=0, counter=0, buffer=0, hence rnd_data=0.
REQ-029 Reset mid-FETCH or mid-FULL discards the buffered word; after release, a fresh sample shall be fetched before any grant.

Configuration
REQ-030 Macro RNG_SOP_ZEROIZE_EN defined: buffer cleared to 0 on the edge ending the grant cycle, and rnd_data forced to 0 whenever rnd_valid=0.
REQ-031 RNG_SOP_ZEROIZE_EN undefined: buffer retains its last value until the next fill, and rnd_data continuously reflects the buffer.

Verification
REQ-032 Reset release, sop_valid=1 at cycle 3 with sop_data=128'hA5..A5 -> rd_sop high cycle 4 only, state FULL, no grant.
REQ-033 FULL, req0=1 only -> gnt0=1, rnd_valid=1, rnd_data=A5..A5 next cycle; next fill then req0 again -> gnt0 again (single requester wins).
REQ-034 FULL, req0=req1=1 held -> grants alternate gnt0, gnt1, gnt0 over three fills; never both high.
REQ-035 STALL_LIMIT=8, FETCH, sop_valid=0, rng_busy=0 -> stall_err high after 9th cycle; rng_busy=1 pulse at cycle 5 restarts count; clr_err=1 clears; later sop_valid=1 still accepted.
REQ-036 Assert rst_n=0 asynchronously during FULL with req1=1 -> all outputs 0 immediately, no gnt1 after release until a new fetch; with RNG_SOP_ZEROIZE_EN, rnd_data=0 the cycle after every grant.
